// File: rtl/gpio_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_gen_pkg
// Purpose  : Shared constants and helpers for the GPIO pattern generator.
//            Mode encodings, bounce direction encodings and the tick divider
//            ratio calculation.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_gen_pkg;

  // Output mode encodings, as presented on the 2-bit mode input
  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_PWM    = 2'd3;

  // Walking-bit direction in bounce mode
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Clock cycles per step period; callers must choose CLK_HZ >= TICK_HZ
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : gpio_tick_div
// Purpose  : Step-rate divider. Counts enabled cycles 0..DIV-1 and flags the
//            last cycle of each period.
// Ports    : CLOCK_50 - clock
//            resetn   - asynchronous active-low reset
//            clr      - synchronous counter clear (takes priority over enable)
//            enable   - count enable; counter holds when low
//            tick     - high while the counter sits at DIV-1 and is enabled
// Revision : 1.0 - initial release
// ============================================================================
module gpio_tick_div #(
  parameter int DIV = 4
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic clr,
  input  logic enable,
  output logic tick
);

  localparam int             c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_wrap;

  // Combinational so the parent can advance its state on the same edge
  // that wraps the counter; the parent registers the visible tick.
  assign w_wrap = enable && !clr && (r_cnt == c_last);
  assign tick   = w_wrap;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpio_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pattern_gen
// Purpose  : GPIO output driver. Latches a mode/pattern/duty on load and
//            drives the bus as static, rotating, bouncing single bit or
//            PWM-dimmed pattern.
// Ports    : CLOCK_50 - clock
//            resetn   - asynchronous active-low reset
//            load     - latch mode, pattern and duty; clears all counters
//            mode     - 0 static, 1 rotate, 2 bounce, 3 PWM
//            pattern  - static value or rotate seed
//            duty     - PWM duty (also tracked live while in PWM mode)
//            enable   - low freezes all counters, state and outputs
//            gpio_out - registered GPIO drive
//            tick     - registered one-cycle pulse per step period
// Revision : 1.0 - initial release
// ============================================================================
module gpio_pattern_gen
  import gpio_gen_pkg::*;
#(
  parameter int GPIO_W   = 32,
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 10,
  parameter int PWM_BITS = 8
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                load,
  input  logic [1:0]          mode,
  input  logic [GPIO_W-1:0]   pattern,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                enable,
  output logic [GPIO_W-1:0]   gpio_out,
  output logic                tick
);

  localparam int                 c_div     = calc_div(CLK_HZ, TICK_HZ);
  localparam int                 c_pos_w   = (GPIO_W > 1) ? $clog2(GPIO_W) : 1;
  localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(GPIO_W - 1);
  localparam logic [GPIO_W-1:0]  c_bit0    = GPIO_W'(1);

  // State registers
  logic [1:0]          r_mode;
  logic [GPIO_W-1:0]   r_pat;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_duty_act;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [c_pos_w-1:0]  r_pos;
  logic                r_dir;
  logic [GPIO_W-1:0]   r_gpio;
  logic                r_tick;

  // Next-state and output wires
  logic [1:0]          w_mode_nxt;
  logic [GPIO_W-1:0]   w_pat_nxt;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [PWM_BITS-1:0] w_duty_act_nxt;
  logic [PWM_BITS-1:0] w_pwm_cnt_nxt;
  logic [c_pos_w-1:0]  w_pos_nxt;
  logic                w_dir_nxt;
  logic [GPIO_W-1:0]   w_gpio_nxt;
  logic [GPIO_W-1:0]   w_pat_rotl;
  logic                w_div_tick;
  logic                w_pwm_on;

  gpio_tick_div #(
    .DIV (c_div)
  ) u_tick_div (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clr      (load),
    .enable   (enable),
    .tick     (w_div_tick)
  );

  // Rotate-left by one; a single-bit bus rotates onto itself
  if (GPIO_W > 1) begin : g_rot_multi
    assign w_pat_rotl = {r_pat[GPIO_W-2:0], r_pat[GPIO_W-1]};
  end else begin : g_rot_single
    assign w_pat_rotl = r_pat;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_mode     <= MODE_STATIC;
      r_pat      <= '0;
      r_duty     <= '0;
      r_duty_act <= '0;
      r_pwm_cnt  <= '0;
      r_pos      <= '0;
      r_dir      <= DIR_LEFT;
      r_gpio     <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_pat      <= w_pat_nxt;
      r_duty     <= w_duty_nxt;
      r_duty_act <= w_duty_act_nxt;
      r_pwm_cnt  <= w_pwm_cnt_nxt;
      r_pos      <= w_pos_nxt;
      r_dir      <= w_dir_nxt;
      // Output reflects the state held before this edge; frozen when disabled
      if (enable) begin
        r_gpio <= w_gpio_nxt;
      end
      // The divider tick is already gated by enable and load
      r_tick <= w_div_tick;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_mode_nxt     = r_mode;
    w_pat_nxt      = r_pat;
    w_duty_nxt     = r_duty;
    w_duty_act_nxt = r_duty_act;
    w_pwm_cnt_nxt  = r_pwm_cnt;
    w_pos_nxt      = r_pos;
    w_dir_nxt      = r_dir;

    if (load) begin
      w_mode_nxt     = mode;
      w_pat_nxt      = pattern;
      w_duty_nxt     = duty;
      w_duty_act_nxt = duty;
      w_pwm_cnt_nxt  = '0;
      w_pos_nxt      = '0;
      w_dir_nxt      = DIR_LEFT;
    end else if (enable) begin
      w_pwm_cnt_nxt = r_pwm_cnt + 1'b1;
      // Adopt the pending duty only at a period boundary so no period is cut
      if (r_pwm_cnt == '1) begin
        w_duty_act_nxt = r_duty;
      end
      if (r_mode == MODE_PWM) begin
        w_duty_nxt = duty;
      end
      if (w_div_tick) begin
        if (r_mode == MODE_ROTATE) begin
          w_pat_nxt = w_pat_rotl;
        end
        // Bounce position runs in every mode; it only shows in bounce mode
        if (GPIO_W > 1) begin
          if (r_dir == DIR_LEFT) begin
            if (r_pos == c_pos_last) begin
              w_dir_nxt = DIR_RIGHT;
              w_pos_nxt = r_pos - 1'b1;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end else begin
            if (r_pos == '0) begin
              w_dir_nxt = DIR_LEFT;
              w_pos_nxt = r_pos + 1'b1;
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  assign w_pwm_on = (r_pwm_cnt < r_duty_act);

  always_comb begin
    w_gpio_nxt = r_pat;
    case (r_mode)
      MODE_STATIC: w_gpio_nxt = r_pat;
      MODE_ROTATE: w_gpio_nxt = r_pat;
      MODE_BOUNCE: w_gpio_nxt = c_bit0 << r_pos;
      MODE_PWM:    w_gpio_nxt = r_pat & {GPIO_W{w_pwm_on}};
      default:     w_gpio_nxt = r_pat;
    endcase
  end

  assign gpio_out = r_gpio;
  assign tick     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pattern_gen
// Purpose  : Scoreboard bench for gpio_pattern_gen with GPIO_W=8, DIV=4,
//            PWM_BITS=4. Directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_pattern_gen;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int PER = 16;  // PWM period

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] duty = 4'd0;
  logic       enable = 1'b0;
  logic [7:0] gpio_out;
  logic       tick;

  always #5 clk = ~clk;

  gpio_pattern_gen #(
    .GPIO_W   (W),
    .CLK_HZ   (100),
    .TICK_HZ  (25),
    .PWM_BITS (4)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .load     (load),
    .mode     (mode),
    .pattern  (pattern),
    .duty     (duty),
    .enable   (enable),
    .gpio_out (gpio_out),
    .tick     (tick)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  // Expected {gpio_out, tick} after each rising edge
  logic [8:0] exp_q[$];

  // Reference model: state expressed as "enabled cycles since load"
  logic [1:0] m_mode;
  logic [7:0] m_seed;
  int         m_duty_r, m_duty_act;
  int         m_e;
  logic [7:0] m_gpio;
  logic       m_tick;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
    logic [15:0] t;
    t = {x, x} << (r % W);
    return t[15:8];
  endfunction

  function automatic int bounce_pos(input int n);
    int p;
    p = n % (2 * (W - 1));
    return (p < W) ? p : 2 * (W - 1) - p;
  endfunction

  function automatic logic [7:0] model_out();
    int n;
    n = m_e / DIV;
    case (m_mode)
      2'd0: return m_seed;
      2'd1: return rotl(m_seed, n);
      2'd2: return 8'(1 << bounce_pos(n));
      default: return ((m_e % PER) < m_duty_act) ? m_seed : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_seed = 8'h00; m_duty_r = 0; m_duty_act = 0;
    m_e = 0; m_gpio = 8'h00; m_tick = 1'b0;
  endtask

  // One clock cycle of stimulus: drive at the falling edge, predict the
  // outputs after the following rising edge and queue them.
  task automatic cyc(input bit ld, input logic [1:0] md, input logic [7:0] pt,
                     input logic [3:0] dt, input bit en);
    @(negedge clk);
    resetn  = 1'b1;
    load    = ld;
    mode    = md;
    pattern = pt;
    duty    = dt;
    enable  = en;
    if (en) m_gpio = model_out();
    if (ld) begin
      m_mode = md; m_seed = pt; m_duty_r = int'(dt); m_duty_act = int'(dt);
      m_e = 0; m_tick = 1'b0;
    end else if (en) begin
      if ((m_e % PER) == PER - 1) m_duty_act = m_duty_r;
      if (m_mode == 2'd3) m_duty_r = int'(dt);
      m_e++;
      m_tick = ((m_e % DIV) == 0);
    end else begin
      m_tick = 1'b0;
    end
    exp_q.push_back({m_gpio, m_tick});
  endtask

  task automatic rst_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      resetn  = 1'b0;
      load    = 1'($urandom);
      mode    = 2'($urandom);
      pattern = 8'($urandom);
      duty    = 4'($urandom);
      enable  = 1'($urandom);
      model_reset();
      exp_q.push_back(9'h000);
    end
  endtask

  task automatic idle(input int k, input logic [3:0] dt, input bit en);
    for (int i = 0; i < k; i++) cyc(1'b0, 2'($urandom), 8'($urandom), dt, en);
  endtask

  // Monitor: compare every rising edge that has a queued expectation
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gpio_out !== e[8:1]) begin
          n_errors++;
          $display("FAIL gpio_out cycle=%0d got=%02h exp=%02h", cyc_no, gpio_out, e[8:1]);
        end
        n_checks++;
        if (tick !== e[0]) begin
          n_errors++;
          $display("FAIL tick cycle=%0d got=%0b exp=%0b", cyc_no, tick, e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    // Reset held for three cycles, then idle without load
    rst_cycles(3);
    idle(6, 4'd0, 1'b1);

    // STATIC
    cyc(1'b1, 2'd0, 8'hA5, 4'd0, 1'b1);
    idle(80, 4'd0, 1'b1);

    // ROTATE with an enable freeze in the middle of a step period
    cyc(1'b1, 2'd1, 8'h81, 4'd0, 1'b1);
    idle(14, 4'd0, 1'b1);
    idle(10, 4'd0, 1'b0);
    idle(14, 4'd0, 1'b1);

    // BOUNCE through two full sweeps
    cyc(1'b1, 2'd2, 8'h00, 4'd0, 1'b1);
    idle(120, 4'd0, 1'b1);

    // PWM duty 4, then 12 set mid-period, then 0
    cyc(1'b1, 2'd3, 8'hFF, 4'd4, 1'b1);
    idle(40, 4'd4, 1'b1);
    idle(40, 4'd12, 1'b1);
    idle(40, 4'd0, 1'b1);

    // Load while disabled, then resume
    cyc(1'b1, 2'd1, 8'h3C, 4'd0, 1'b0);
    idle(3, 4'd0, 1'b0);
    idle(12, 4'd0, 1'b1);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) rst_cycles(2);
      cyc(($urandom_range(0, 19) == 0), 2'($urandom), 8'($urandom),
          4'($urandom), ($urandom_range(0, 99) < 85));
    end

    // Let the monitor drain the queue
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_pattern_gen.md
Name: gpio_pattern_gen

Overview:
- Parametrised GPIO output driver for the 40-pin header demos; the successor to the fixed switch-to-GPIO output demo.
- Latches a pattern and a mode, then drives a GPIO_W-bit output bus as one of four modes: static, rotate, bounce (single walking bit) or PWM-dimmed.
- Step rate comes from an internal tick divider; PWM runs at clock rate.
- Sits between board inputs (SW/KEY) and the GPIO bus in a demo top.

Parameters:
- GPIO_W, 32, output bus width (>=1)
- CLK_HZ, 50000000, input clock frequency
- TICK_HZ, 10, step rate for the rotate and bounce modes; DIV = CLK_HZ/TICK_HZ, which must be >=1
- PWM_BITS, 8, PWM counter and duty width

Ports:
- CLOCK_50  in   1         system clock; one clock domain
- resetn    in   1         asynchronous active-low reset
- load      in   1         synchronous pulse; latches mode, pattern and duty
- mode      in   2         0 STATIC, 1 ROTATE, 2 BOUNCE, 3 PWM; sampled only on load
- pattern   in   GPIO_W    seed or static value; sampled only on load
- duty      in   PWM_BITS  PWM duty; sampled on load
- enable    in   1         0 freezes all counters and state; outputs hold
- gpio_out  out  GPIO_W    registered GPIO drive
- tick      out  1         one-cycle pulse each step period

Behaviour:
- Reset (async assert, sync release):
  - gpio_out=0, tick=0, mode_r=STATIC, pat_r=0, duty_r=0, duty_act=0
  - div_cnt=0, pwm_cnt=0, pos=0, dir=LEFT
- All outputs are registered. Any state change appears on gpio_out in the following cycle.
- Tick divider:
  - When enable=1, div_cnt counts 0..DIV-1.
  - tick=1 in the cycle where div_cnt==DIV-1, then div_cnt wraps to 0.
  - DIV=1 gives tick=1 every enabled cycle.
- load=1 (has priority over tick in the same cycle):
  - mode_r<=mode, pat_r<=pattern, duty_r<=duty, duty_act<=duty
  - div_cnt<=0, pwm_cnt<=0, pos<=0, dir<=LEFT, tick<=0
- load is honoured even when enable=0.
- enable=0 with no load: all counters and state hold; gpio_out holds its last value; tick=0.
- STATIC: gpio_out=pat_r.
- ROTATE: on each tick, pat_r<=rotate-left-by-1 (MSB wraps into the LSB); gpio_out=pat_r. GPIO_W=1 is a no-op.
- BOUNCE:
  - gpio_out is a one-hot bit at position pos; pat_r is ignored.
  - On tick, LEFT: if pos==GPIO_W-1 then dir<=RIGHT, pos<=pos-1; else pos<=pos+1.
  - On tick, RIGHT: if pos==0 then dir<=LEFT, pos<=pos+1; else pos<=pos-1.
  - The end bits are lit for one step only; the sequence for W=4 is 0,1,2,3,2,1,0,1...
  - GPIO_W=1: pos stays 0.
  - pos width is max(1,$clog2(GPIO_W)).
- PWM:
  - pwm_cnt increments every enabled cycle, modulo 2^PWM_BITS.
  - on = (pwm_cnt < duty_act); gpio_out = pat_r & {GPIO_W{on}}.
  - duty_act<=duty_r only when pwm_cnt wraps to 0, so a mid-period duty change is glitch-free.
  - duty=0 gives always off; duty=2^PWM_BITS-1 gives on for 255 of every 256 cycles (PWM_BITS=8).
  - In PWM mode, duty is also resampled into duty_r every cycle. This allows live dimming without a reload.
- Mode changes take effect only through load. Unused mode state (pos, pwm_cnt) keeps running but has no output effect.
- Reset mid-operation: immediate return to the reset values; no partial-state carryover.

Decomposition:
- Package gpio_gen_pkg holds:
  - 2-bit mode constants MODE_STATIC/ROTATE/BOUNCE/PWM
  - direction constants DIR_LEFT/DIR_RIGHT
  - localparam function computing DIV
- Sub-module gpio_tick_div(CLOCK_50, resetn, clr, enable, tick), parametrised by DIV.
- The main module holds the mode FSM (mode_r, pos/dir), the PWM counter and the output register.

Test Plan:
All scenarios use GPIO_W=8, CLK_HZ=100, TICK_HZ=25 (DIV=4), PWM_BITS=4 unless noted.
- Reset: hold resetn=0 for 3 cycles with any inputs -> gpio_out=0x00, tick=0. Release -> still 0x00 until load.
- STATIC: load mode=0, pattern=0xA5 -> gpio_out=0xA5 one cycle later; stable across 20 ticks.
- ROTATE: load mode=1, pattern=0x81 -> after successive ticks gpio_out=0x03, 0x06, 0x0C. Tick spacing is exactly 4 cycles.
- Enable freeze: in ROTATE, drop enable for 10 cycles -> gpio_out is unchanged and tick=0; resume -> the next tick lands the remaining count of cycles later.
- BOUNCE: load mode=2 -> gpio_out sequence per tick is 0x01, 0x02 ... 0x80, 0x40 ... 0x01, 0x02. 0x80 and 0x01 each appear for only one step.
- PWM:
  - load mode=3, pattern=0xFF, duty=4 -> gpio_out=0xFF for 4 of every 16 cycles.
  - Change duty to 12 mid-period -> the new ratio starts at the next pwm_cnt wrap.
  - duty=0 -> gpio_out is always 0x00.
